// File: rtl/uart_cmd_unit_if.sv
// uart_cmd_unit_if: byte-stream, bridge and transmitter signals of the UART command unit.
// The master modport is the command unit; the slave modport is its environment.
interface uart_cmd_unit_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] word_out;
    logic        word_out_en;
    logic [2:0]  wr_sel;
    logic [27:0] init_addr;
    logic        init_addr_en;
    logic [31:0] rd_data;
    logic        rd_data_en;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        err;

    modport master (
        input  rx_data, rx_valid, rd_data, rd_data_en, tx_ready,
        output word_out, word_out_en, wr_sel, init_addr, init_addr_en,
        output tx_data, tx_valid, busy, err
    );

    modport slave (
        output rx_data, rx_valid, rd_data, rd_data_en, tx_ready,
        input  word_out, word_out_en, wr_sel, init_addr, init_addr_en,
        input  tx_data, tx_valid, busy, err
    );
endinterface

// File: rtl/uart_cmd_unit.sv
// uart_cmd_unit: decodes UART opcodes (0x41 set address, 0x57 write, 0x52 read) with
// 4-byte little-endian arguments, issues bridge strobes and streams read words back LSB first.
// Optional: define UART_CMD_TIMEOUT_EN to abort ARG/WAIT_RD after TIMEOUT_CYCLES idle cycles.
module uart_cmd_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input logic             clk,
    input logic             rst_n,
    uart_cmd_unit_if.master bus_io
);
    typedef enum logic [2:0] {IDLE, ARG, ISSUE, WAIT_RD, TX} state_e;
    typedef enum logic [1:0] {OP_ADDR, OP_WRITE, OP_READ} op_e;

    state_e      state_q;
    op_e         op_q;
    logic [1:0]  cnt_q;
    logic [23:0] asm_q;
    logic [23:0] shift_q;
    logic [31:0] word_out_q;
    logic        word_out_en_q;
    logic [27:0] init_addr_q;
    logic        init_addr_en_q;
    logic [2:0]  wr_sel_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic        err_q;
    logic [31:0] full_d;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_CYCLES - 1);
    logic [IW-1:0] idle_q;
`endif

    // Three collected bytes plus the byte arriving now form the complete argument word.
    assign full_d = {bus_io.rx_data, asm_q};

    assign bus_io.word_out     = word_out_q;
    assign bus_io.word_out_en  = word_out_en_q;
    assign bus_io.wr_sel       = wr_sel_q;
    assign bus_io.init_addr    = init_addr_q;
    assign bus_io.init_addr_en = init_addr_en_q;
    assign bus_io.tx_data      = tx_data_q;
    assign bus_io.tx_valid     = tx_valid_q;
    assign bus_io.busy         = state_q != IDLE;
    assign bus_io.err          = err_q;

    // Command FSM; strobes are registered on the edge that enters ISSUE so they coincide with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            op_q           <= OP_ADDR;
            cnt_q          <= '0;
            asm_q          <= '0;
            shift_q        <= '0;
            word_out_q     <= '0;
            word_out_en_q  <= 1'b0;
            init_addr_q    <= '0;
            init_addr_en_q <= 1'b0;
            wr_sel_q       <= '0;
            tx_data_q      <= '0;
            tx_valid_q     <= 1'b0;
            err_q          <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
            idle_q         <= '0;
`endif
        end else begin
            word_out_en_q  <= 1'b0;
            init_addr_en_q <= 1'b0;
            wr_sel_q       <= '0;
            err_q          <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
            idle_q         <= '0;
`endif
            case (state_q)
                IDLE: begin
                    if (bus_io.rx_valid) begin
                        cnt_q <= '0;
                        if (bus_io.rx_data == 8'h41) begin
                            op_q    <= OP_ADDR;
                            state_q <= ARG;
                        end else if (bus_io.rx_data == 8'h57) begin
                            op_q    <= OP_WRITE;
                            state_q <= ARG;
                        end else if (bus_io.rx_data == 8'h52) begin
                            op_q     <= OP_READ;
                            wr_sel_q <= 3'b010;
                            state_q  <= ISSUE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ARG: begin
                    if (bus_io.rx_valid) begin
                        asm_q <= {bus_io.rx_data, asm_q[23:8]};
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_q <= ISSUE;
                            if (op_q == OP_ADDR) begin
                                init_addr_q    <= full_d[27:0];
                                init_addr_en_q <= 1'b1;
                            end else begin
                                word_out_q    <= full_d;
                                word_out_en_q <= 1'b1;
                                wr_sel_q      <= 3'b100;
                            end
                        end
                    end
`ifdef UART_CMD_TIMEOUT_EN
                    else if (idle_q == IDLE_LIMIT) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
`endif
                end
                ISSUE: begin
                    err_q   <= bus_io.rx_valid;
                    state_q <= (op_q == OP_READ) ? WAIT_RD : IDLE;
                end
                WAIT_RD: begin
                    err_q <= bus_io.rx_valid;
                    if (bus_io.rd_data_en) begin
                        tx_data_q  <= bus_io.rd_data[7:0];
                        shift_q    <= bus_io.rd_data[31:8];
                        tx_valid_q <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= TX;
                    end
`ifdef UART_CMD_TIMEOUT_EN
                    else if (idle_q == IDLE_LIMIT) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
`endif
                end
                TX: begin
                    err_q <= bus_io.rx_valid;
                    if (tx_valid_q && bus_io.tx_ready) begin
                        cnt_q     <= cnt_q + 2'd1;
                        tx_data_q <= shift_q[7:0];
                        shift_q   <= {8'h00, shift_q[23:8]};
                        if (cnt_q == 2'd3) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_unit.sv
// tb_uart_cmd_unit: directed and randomized command traffic checked against a transaction-level model.
module tb_uart_cmd_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_cmd_unit_if bus ();
    uart_cmd_unit #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst_n(rst_n), .bus_io(bus));

    int checks = 0;
    int passed = 0;

    // Observed activity, gathered once per cycle on the falling edge.
    int n_word = 0, n_init = 0, n_wr100 = 0, n_wr100_en = 0, n_rd = 0, n_bad = 0, n_err = 0;
    logic [31:0] last_word = '0;
    logic [27:0] last_init = '0;
    logic [7:0]  q_act[$];
    logic        hold = 1'b0;
    logic [7:0]  held = '0;

    // Expected activity, derived from the commands the bench sends.
    int e_word = 0, e_init = 0, e_wr100 = 0, e_rd = 0, e_err = 0;
    logic [31:0] e_last_word = '0;
    logic [27:0] e_last_init = '0;
    logic [7:0]  q_exp[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Falling-edge monitor: counts strobes, records accepted tx bytes, checks tx hold.
    always @(negedge clk) begin
        if (bus.word_out_en) begin n_word++; last_word = bus.word_out; end
        if (bus.init_addr_en) begin n_init++; last_init = bus.init_addr; end
        if (bus.wr_sel == 3'b100) begin n_wr100++; if (bus.word_out_en) n_wr100_en++; end
        if (bus.wr_sel == 3'b010) n_rd++;
        if (bus.wr_sel != 3'b000 && bus.wr_sel != 3'b100 && bus.wr_sel != 3'b010) n_bad++;
        if (bus.err) n_err++;
        if (bus.tx_valid && bus.tx_ready) q_act.push_back(bus.tx_data);
        if (hold) begin
            chk("tx_hold_valid", 32'(bus.tx_valid), 32'd1);
            chk("tx_hold_data", 32'(bus.tx_data), 32'(held));
        end
        hold = bus.tx_valid && !bus.tx_ready;
        held = bus.tx_data;
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic verify(input string tag);
        @(posedge clk); #1;
        chk({tag, "_nword"}, 32'(n_word), 32'(e_word));
        chk({tag, "_ninit"}, 32'(n_init), 32'(e_init));
        chk({tag, "_nwr100"}, 32'(n_wr100), 32'(e_wr100));
        chk({tag, "_wr100_with_en"}, 32'(n_wr100_en), 32'(e_wr100));
        chk({tag, "_nrd"}, 32'(n_rd), 32'(e_rd));
        chk({tag, "_nbad"}, 32'(n_bad), 32'd0);
        chk({tag, "_nerr"}, 32'(n_err), 32'(e_err));
        chk({tag, "_word"}, last_word, e_last_word);
        chk({tag, "_init"}, 32'(last_init), 32'(e_last_init));
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    // Opcode followed by the 32-bit argument, little-endian; checks the strobe the cycle after the last byte.
    task automatic cmd(input logic [7:0] op, input logic [31:0] w);
        send(op);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
        if (op == 8'h41) begin
            e_init++;
            e_last_init = w[27:0];
            chk("addr_strobe", 32'(bus.init_addr_en), 32'd1);
            chk("addr_value", 32'(bus.init_addr), 32'(w[27:0]));
            chk("addr_wr_sel", 32'(bus.wr_sel), 32'd0);
        end else begin
            e_word++;
            e_wr100++;
            e_last_word = w;
            chk("wr_strobe", 32'(bus.word_out_en), 32'd1);
            chk("wr_wr_sel", 32'(bus.wr_sel), 32'b100);
            chk("wr_value", bus.word_out, w);
        end
    endtask

    task automatic read(input logic [31:0] d, input bit toggle, input bit inject);
        send(8'h52);
        e_rd++;
        chk("rd_wr_sel", 32'(bus.wr_sel), 32'b010);
        @(posedge clk); #1;
        chk("rd_wr_sel_off", 32'(bus.wr_sel), 32'd0);
        chk("rd_wait_busy", 32'(bus.busy), 32'd1);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        bus.tx_ready   = 1'b0;
        bus.rd_data    = d;
        bus.rd_data_en = 1'b1;
        @(posedge clk); #1;
        bus.rd_data_en = 1'b0;
        bus.rd_data    = $urandom;
        chk("tx_first_valid", 32'(bus.tx_valid), 32'd1);
        chk("tx_first_data", 32'(bus.tx_data), 32'(d[7:0]));
        for (int i = 0; i < 4; i++) q_exp.push_back(d[8*i +: 8]);
        if (inject) e_err++;
        for (int i = 0; i < 200 && bus.busy; i++) begin
            if (inject && i == 0) begin bus.rx_valid = 1'b1; bus.rx_data = $urandom; end
            if (i == 1) bus.rx_valid = 1'b0;
            @(posedge clk); #1;
            bus.tx_ready = toggle ? ~bus.tx_ready : 1'($urandom);
        end
        bus.rx_valid = 1'b0;
        chk("tx_done", 32'(bus.busy), 32'd0);
        chk("tx_valid_drop", 32'(bus.tx_valid), 32'd0);
        bus.tx_ready = 1'b0;
        @(posedge clk); #1;
        chk("tx_count", 32'(q_act.size()), 32'(q_exp.size()));
        for (int i = 0; i < q_exp.size() && i < q_act.size(); i++)
            chk("tx_byte", 32'(q_act[i]), 32'(q_exp[i]));
        q_act.delete();
        q_exp.delete();
    endtask

    task automatic bad(input logic [7:0] b);
        send(b);
        e_err++;
        chk("bad_err", 32'(bus.err), 32'd1);
        chk("bad_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        bus.rx_valid = 1'b0;
        bus.rx_data = '0;
        bus.rd_data = '0;
        bus.rd_data_en = 1'b0;
        bus.tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_word_out", bus.word_out, 32'd0);
        chk("rst_word_en", 32'(bus.word_out_en), 32'd0);
        chk("rst_init_addr", 32'(bus.init_addr), 32'd0);
        chk("rst_init_en", 32'(bus.init_addr_en), 32'd0);
        chk("rst_wr_sel", 32'(bus.wr_sel), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;

        cmd(8'h41, 32'h12345678);
        verify("set_addr");
        cmd(8'h57, 32'hDEADBEEF);
        verify("write");
        read(32'hCAFEF00D, 1'b1, 1'b0);
        verify("read");

        @(posedge clk); #1;
        bus.rd_data = $urandom;
        bus.rd_data_en = 1'b1;
        @(posedge clk); #1;
        bus.rd_data_en = 1'b0;
        chk("stray_rd_busy", 32'(bus.busy), 32'd0);
        chk("stray_rd_tx", 32'(bus.tx_valid), 32'd0);

        bad(8'h99);
        cmd(8'h57, 32'h00000001);
        verify("bad_then_write");

        // A byte landing in the ISSUE cycle is dropped with an error.
        send(8'h57);
        for (int i = 0; i < 3; i++) send(8'(i + 5));
        @(posedge clk); #1;
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'hA5;
        @(posedge clk); #1;
        bus.rx_data = 8'h41;
        chk("issue_strobe", 32'(bus.word_out_en), 32'd1);
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        chk("issue_drop_err", 32'(bus.err), 32'd1);
        chk("issue_drop_busy", 32'(bus.busy), 32'd0);
        e_word++; e_wr100++; e_err++;
        e_last_word = 32'hA5070605;
        verify("issue_collision");

        send(8'h57); send(8'h11); send(8'h22);
`ifdef UART_CMD_TIMEOUT_EN
        repeat (16) @(posedge clk);
        #1;
        chk("timeout_err", 32'(bus.err), 32'd1);
        chk("timeout_idle", 32'(bus.busy), 32'd0);
        e_err++;
        verify("timeout");
`else
        repeat (40) @(posedge clk);
        #1;
        chk("no_timeout_busy", 32'(bus.busy), 32'd1);
        chk("no_timeout_err", 32'(n_err), 32'(e_err));
        send(8'h33); send(8'h44);
        e_word++; e_wr100++;
        e_last_word = 32'h44332211;
        verify("no_timeout");
`endif

        send(8'h57); send(8'h11); send(8'h22);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_word", bus.word_out, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'h33);
        chk("midrst_err33", 32'(bus.err), 32'd1);
        send(8'h44);
        e_err += 2;
        verify("midrst");

        for (int n = 0; n < 25; n++) begin
            case ($urandom_range(0, 3))
                0: cmd(8'h41, $urandom);
                1: cmd(8'h57, $urandom);
                2: read($urandom, 1'($urandom), 1'($urandom));
                default: begin
                    b = 8'($urandom);
                    if (b == 8'h41 || b == 8'h57 || b == 8'h52) b = 8'hFF;
                    bad(b);
                end
            endcase
        end
        verify("random");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/uart_cmd_unit.md
UART_CMD_UNIT -- requirements
Module: uart_cmd_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning the inter-byte/read-wait abort limit in clk cycles (used only with UART_CMD_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset: asynchronous, active-low.
REQ-004 SHALL have port rx_data  input  8  received UART byte.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe; rx_data is valid.
REQ-006 SHALL have port word_out  output  32  assembled write word (to bus bridge).
REQ-007 SHALL have port word_out_en  output  1  one-cycle strobe; word_out is valid.
REQ-008 SHALL have port wr_sel  output  3  request: 3'b100 write, 3'b010 read, else 3'b000.
REQ-009 SHALL have port init_addr  output  28  start address for the bridge.
REQ-010 SHALL have port init_addr_en  output  1  one-cycle strobe; load init_addr.
REQ-011 SHALL have port rd_data  input  32  read word returned by the bridge.
REQ-012 SHALL have port rd_data_en  input  1  rd_data is valid.
REQ-013 SHALL have port tx_data  output  8  byte to UART transmitter.
REQ-014 SHALL have port tx_valid  output  1  tx_data is valid.
REQ-015 SHALL have port tx_ready  input  1  transmitter accepts tx_data.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-017 SHALL have port err  output  1  one-cycle strobe on a protocol error.

Function
REQ-018 SHALL implement FSM states IDLE, ARG, ISSUE, WAIT_RD, TX; every transition is registered.
REQ-019 In IDLE, a byte strobed by rx_valid SHALL be decoded as an opcode: 0x41 (set address) -> ARG, 0x57 (write) -> ARG, 0x52 (read) -> ISSUE; any other value -> err pulse, stay IDLE.
REQ-020 ARG SHALL collect exactly 4 bytes, little-endian (first byte goes to bits [7:0]), with a 2-bit byte counter reset on entry; after the 4th byte the FSM SHALL go to ISSUE.
REQ-021 ISSUE SHALL last exactly 1 cycle and then return to IDLE for opcodes 0x41 and 0x57, or go to WAIT_RD for opcode 0x52.
REQ-022 ISSUE for 0x41 SHALL pulse init_addr_en with init_addr = assembled[27:0]; bits [31:28] are discarded.
REQ-023 ISSUE for 0x57 SHALL pulse word_out_en and drive wr_sel=3'b100 in the same single cycle, with word_out = assembled word.
REQ-024 ISSUE for 0x52 SHALL drive wr_sel=3'b010 for exactly one cycle.
REQ-025 wr_sel SHALL be 3'b000 in every cycle except those given in REQ-023 and REQ-024.
REQ-026 word_out SHALL hold its last value between pulses.
REQ-027 In WAIT_RD, rd_data_en high SHALL capture rd_data into a shift register and move to TX.
REQ-028 TX SHALL send 4 bytes LSB first; tx_valid stays high and tx_data stable until a cycle with tx_valid && tx_ready; after the 4th accepted byte, tx_valid SHALL drop and the FSM SHALL return to IDLE.
REQ-029 rx_valid in WAIT_RD or TX SHALL drop the byte and pulse err; the state SHALL be unchanged.
REQ-030 rx_valid coinciding with an ISSUE cycle SHALL be dropped and SHALL pulse err.
REQ-031 rd_data_en outside WAIT_RD SHALL be ignored.
REQ-032 Output latency: the ISSUE strobe SHALL occur 1 cycle after the cycle in which the last argument byte is strobed; the first tx_valid SHALL occur 1 cycle after rd_data_en.

Reset
REQ-033 rst_n low SHALL asynchronously force state IDLE, counters 0, word_out 0, init_addr 0, tx_data 0, and word_out_en, init_addr_en, wr_sel, tx_valid, busy, err all 0.
REQ-034 Reset asserted mid-frame or mid-TX SHALL discard the partial command; no strobe is issued after release until a new complete command arrives.

Configuration
REQ-035 With UART_CMD_TIMEOUT_EN defined, an idle counter SHALL count cycles without rx_valid in ARG, and cycles without rd_data_en in WAIT_RD.
REQ-036 With UART_CMD_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL pulse err and return the FSM to IDLE, discarding partial data.
REQ-037 With UART_CMD_TIMEOUT_EN defined, the idle counter SHALL clear on every state entry and on every accepted byte.
REQ-038 Without UART_CMD_TIMEOUT_EN, no counter SHALL exist, ARG and WAIT_RD SHALL wait indefinitely, and TIMEOUT_CYCLES SHALL be unused.

Verification
REQ-039 Bytes 41 78 56 34 12 -> one init_addr_en pulse with init_addr=28'h2345678; wr_sel stays 0.
REQ-040 Bytes 57 EF BE AD DE -> word_out=32'hDEADBEEF, and word_out_en and wr_sel=3'b100 high in the same single cycle.
REQ-041 Byte 52, then rd_data=32'hCAFEF00D with rd_data_en, tx_ready toggling 1/0 -> wr_sel=3'b010 for one cycle, then tx bytes 0D F0 FE CA in order, each held until accepted.
REQ-042 Byte 99 -> err pulse, busy stays 0; a following 57 01 00 00 00 -> word_out=1.
REQ-043 With TIMEOUT_CYCLES=16, bytes 57 11 22 and then 16 idle cycles -> err pulse, return to IDLE, no word_out_en.
REQ-044 Bytes 57 11 22 and rst_n low for 2 cycles, then 33 44 -> no strobes and err pulse on 33 (0x33 is an invalid opcode).
